mem_access_ctrl: RTL

//  MEM-stage data-memory access controller; consumes decoded memory-control fields (read/write/sign-ext flags, sel, write data) plus the ALU address.

---
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: steers store bytes onto a ready-handshaked
// bus, stalls the pipeline until the bus completes, and returns aligned/extended load data.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_read_flag,
    input  logic                      mem_write_flag,
    input  logic                      mem_sign_ext_flag,
    input  logic [DATA_WIDTH/8-1:0]   mem_sel,
    input  logic [DATA_WIDTH-1:0]     mem_write_data,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic                      flush,
    output logic                      bus_en,
    output logic [DATA_WIDTH/8-1:0]   bus_we,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [DATA_WIDTH-1:0]     bus_wdata,
    input  logic [DATA_WIDTH-1:0]     bus_rdata,
    input  logic                      bus_ready,
    output logic                      stall_req,
    output logic [DATA_WIDTH-1:0]     load_data,
    output logic                      load_valid,
    output logic                      addr_err_load,
    output logic                      addr_err_store
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);

    // Bus handshake: bus_en/bus_we/bus_addr/bus_wdata are held stable from the first
    // BUSY cycle until the cycle in which bus_ready=1; that cycle completes the transfer.
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t state, state_next;

    logic [OFF_W-1:0]      off;
    logic                  access;
    logic                  misaligned;
    logic                  launch;
    logic                  err_cand;
    size_t                 size_in;
    logic [BE_W-1:0]       we_in;
    logic [DATA_WIDTH-1:0] wdata_in;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BE_W-1:0]       we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    size_t                 size_q;
    logic                  sx_q;
    logic                  is_load_q;
    logic                  flushed_q;
    logic [OFF_W-1:0]      off_q;
    logic [DATA_WIDTH-1:0] load_q;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_ext;

    assign off        = mem_addr[OFF_W-1:0];
    assign access     = (mem_read_flag || mem_write_flag) && (mem_sel != '0);
    assign misaligned = ((mem_sel == BE_W'(3)) && off[0]) ||
                        ((mem_sel == '1) && (off != '0));
    assign launch     = (state == S_IDLE) && access && !misaligned && !flush;
    assign err_cand   = (state == S_IDLE) && access && misaligned && !flush;

    assign addr_err_load  = err_cand && mem_read_flag;
    assign addr_err_store = err_cand && mem_write_flag && !mem_read_flag;
    assign load_data      = load_q;

    always_comb begin
        size_in = SZ_BYTE;
        if (mem_sel == '1)
            size_in = SZ_WORD;
        else if (mem_sel[1])
            size_in = SZ_HALF;
    end

    always_comb begin
        we_in = mem_write_flag ? BE_W'(mem_sel << off) : '0;
        case (size_in)
            SZ_BYTE: wdata_in = {BE_W{mem_write_data[7:0]}};
            SZ_HALF: wdata_in = {(BE_W/2){mem_write_data[15:0]}};
            default: wdata_in = mem_write_data;
        endcase
    end

    // Load extraction works on the registered offset/size of the in-flight access.
    always_comb begin
        rd_shift = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_BYTE: rd_ext = {{(DATA_WIDTH-8){sx_q & rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: rd_ext = {{(DATA_WIDTH-16){sx_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_req  = 1'b0;
        bus_en     = 1'b0;
        bus_we     = '0;
        bus_addr   = '0;
        bus_wdata  = '0;
        load_valid = 1'b0;
        case (state)
            S_IDLE: begin
                stall_req = launch;
                if (launch)
                    state_next = S_BUSY;
            end
            S_BUSY: begin
                stall_req = 1'b1;
                bus_en    = 1'b1;
                bus_we    = we_q;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                if (bus_ready)
                    state_next = S_DONE;
            end
            S_DONE: begin
                load_valid = is_load_q && !flushed_q && !flush;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            we_q      <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_BYTE;
            sx_q      <= 1'b0;
            is_load_q <= 1'b0;
            flushed_q <= 1'b0;
            off_q     <= '0;
            load_q    <= '0;
        end else begin
            if (launch) begin
                addr_q    <= {mem_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                we_q      <= we_in;
                wdata_q   <= wdata_in;
                size_q    <= size_in;
                sx_q      <= mem_sign_ext_flag;
                is_load_q <= mem_read_flag;
                flushed_q <= 1'b0;
                off_q     <= off;
            end
            // A flush while BUSY lets the bus finish but cancels the writeback.
            if (state == S_BUSY && flush)
                flushed_q <= 1'b1;
            if (state == S_BUSY && bus_ready)
                load_q <= rd_ext;
        end
    end
endmodule
